// File: rtl/id_stage.sv
// id_stage: instruction-decode stage between fetch and execute.
// Holds the IF/ID register, splits the 20-bit instruction into fields and
// presents a registered ID/EX bundle.  It also drives the fetch control
// signals for ID jumps, execute redirects and load-use stalls.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ins, current_address instruction and its PC from fetch
//   ex_redirect, ex_target taken branch resolved in execute
//   jmp_loc, pc_mux_sel  next-PC target / 1 = sequential, 0 = load jmp_loc
//   stall, stall_pm      hold PC / hold program-memory output register
//   rs1_addr, rs2_addr   register-file read addresses (from IF/ID)
//   idex_*               registered ID/EX bundle
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ins,
    input  logic [7:0]  current_address,
    input  logic        ex_redirect,
    input  logic [7:0]  ex_target,
    output logic [7:0]  jmp_loc,
    output logic        pc_mux_sel,
    output logic        stall,
    output logic        stall_pm,
    output logic [2:0]  rs1_addr,
    output logic [2:0]  rs2_addr,
    output logic        idex_valid,
    output logic [4:0]  idex_opcode,
    output logic [2:0]  idex_rd,
    output logic [2:0]  idex_rs1,
    output logic [2:0]  idex_rs2,
    output logic [7:0]  idex_imm,
    output logic [7:0]  idex_pc
);

    localparam logic [4:0] NOP_OP   = 5'b00000;
    localparam logic [4:0] LOAD_OP  = 5'b10100;
    localparam logic [4:0] STORE_OP = 5'b10101;
    localparam logic [4:0] JMP_OP   = 5'b11000;

    typedef enum logic [1:0] {RUN, HAZ, FLUSH} state_t;

    state_t      state;
    logic [19:0] ifid_ins;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;
    logic [7:0]  jmp_hold;

    logic [4:0]  f_op;
    logic [2:0]  f_rd, f_rs1, f_rs2;
    logic [7:0]  f_imm;
    logic        rs2_real;
    logic        haz;
    logic        idj;

    assign f_op  = ifid_ins[19:15];
    assign f_rd  = ifid_ins[14:12];
    assign f_rs1 = ifid_ins[11:9];
    assign f_rs2 = ifid_ins[8:6];
    assign f_imm = ifid_ins[7:0];

    assign rs1_addr = f_rs1;
    assign rs2_addr = f_rs2;

    // imm8 overlaps rs2, so rs2 only counts for register-ALU ops and stores.
    assign rs2_real = !f_op[4] || (f_op == STORE_OP);

    // After any redirect IF/ID always holds a bubble, so FLUSH can never
    // raise a hazard or an ID jump; the state gate only makes that explicit.
    always_comb begin
        haz = 1'b0;
        if (state != FLUSH && idex_valid && idex_opcode == LOAD_OP &&
            ifid_valid && f_op != JMP_OP &&
            (idex_rd == f_rs1 || (rs2_real && idex_rd == f_rs2)))
            haz = 1'b1;
    end

    assign idj = (state != FLUSH) && ifid_valid && (f_op == JMP_OP) && !haz;

    always_comb begin
        jmp_loc    = jmp_hold;
        pc_mux_sel = 1'b1;
        stall      = 1'b0;
        stall_pm   = 1'b0;
        if (ex_redirect) begin
            jmp_loc    = ex_target;
            pc_mux_sel = 1'b0;
        end else if (haz) begin
            stall    = 1'b1;
            stall_pm = 1'b1;
        end else if (idj) begin
            jmp_loc    = f_imm;
            pc_mux_sel = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            jmp_hold    <= '0;
            ifid_ins    <= '0;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            idex_valid  <= 1'b0;
            idex_opcode <= NOP_OP;
            idex_rd     <= '0;
            idex_rs1    <= '0;
            idex_rs2    <= '0;
            idex_imm    <= '0;
            idex_pc     <= '0;
        end else begin
            jmp_hold <= jmp_loc;
            if (ex_redirect || haz) begin
                // Both cases put a bubble into ID/EX.
                idex_valid  <= 1'b0;
                idex_opcode <= NOP_OP;
                idex_rd     <= '0;
                idex_rs1    <= '0;
                idex_rs2    <= '0;
                idex_imm    <= '0;
                idex_pc     <= '0;
            end else begin
                idex_valid  <= ifid_valid;
                idex_opcode <= f_op;
                idex_rd     <= f_rd;
                idex_rs1    <= f_rs1;
                idex_rs2    <= f_rs2;
                idex_imm    <= f_imm;
                idex_pc     <= ifid_pc;
            end

            if (ex_redirect || idj) begin
                ifid_ins   <= '0;
                ifid_pc    <= '0;
                ifid_valid <= 1'b0;
                state      <= FLUSH;
            end else if (haz) begin
                state <= HAZ;
            end else begin
                ifid_ins   <= ins;
                ifid_pc    <= current_address;
                ifid_valid <= 1'b1;
                state      <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed test of id_stage covering sequential decode, reset,
// ID jumps, load-use stalls, rs2 aliasing on JMP and execute redirects.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ins;
    logic [7:0]  current_address;
    logic        ex_redirect;
    logic [7:0]  ex_target;
    logic [7:0]  jmp_loc;
    logic        pc_mux_sel, stall, stall_pm;
    logic [2:0]  rs1_addr, rs2_addr;
    logic        idex_valid;
    logic [4:0]  idex_opcode;
    logic [2:0]  idex_rd, idex_rs1, idex_rs2;
    logic [7:0]  idex_imm, idex_pc;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
        .ex_redirect(ex_redirect), .ex_target(ex_target), .jmp_loc(jmp_loc),
        .pc_mux_sel(pc_mux_sel), .stall(stall), .stall_pm(stall_pm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .idex_valid(idex_valid),
        .idex_opcode(idex_opcode), .idex_rd(idex_rd), .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2), .idex_imm(idex_imm), .idex_pc(idex_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] alu(input logic [2:0] rd, rs1, rs2);
        return {5'b00001, rd, rs1, rs2, 6'b000000};
    endfunction

    function automatic logic [19:0] ld(input logic [2:0] rd, rs1);
        return {5'b10100, rd, rs1, 3'b000, 6'b000000};
    endfunction

    function automatic logic [19:0] jmp(input logic [7:0] tgt);
        return {5'b11000, 3'b000, 4'b0000, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [19:0] i, input logic [7:0] pc);
        ins = i;
        current_address = pc;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ins = '0; current_address = '0;
        ex_redirect = 1'b0; ex_target = '0;
        #12;
        check("rst_jmp_loc", jmp_loc, 8'h00);
        check("rst_pc_mux_sel", pc_mux_sel, 1);
        check("rst_stall", {stall, stall_pm}, 2'b00);
        check("rst_idex_valid", idex_valid, 0);
        check("rst_idex_fields", {idex_opcode, idex_rd, idex_rs1, idex_rs2, idex_imm, idex_pc}, 0);
        tick();
        reset = 1'b0;

        // Sequential stream PCs 0..3
        feed(alu(3'd1, 3'd2, 3'd3), 8'd0); tick();
        feed(alu(3'd2, 3'd1, 3'd0), 8'd1); tick();
        check("seq_pc0", {idex_valid, idex_pc}, {1'b1, 8'd0});
        check("seq_fields0", {idex_opcode, idex_rd, idex_rs1, idex_rs2}, {5'b00001, 3'd1, 3'd2, 3'd3});
        feed(alu(3'd3, 3'd1, 3'd2), 8'd2); tick();
        check("seq_pc1", {idex_valid, idex_pc}, {1'b1, 8'd1});
        feed(alu(3'd4, 3'd3, 3'd2), 8'd3);
        check("seq_rs_addr", {rs1_addr, rs2_addr}, {3'd1, 3'd2});
        tick();
        check("seq_pc2", {idex_valid, idex_pc}, {1'b1, 8'd2});
        feed(alu(3'd5, 3'd0, 3'd0), 8'd4);
        check("seq_mux", pc_mux_sel, 1);
        tick();
        check("seq_pc3", {idex_valid, idex_pc}, {1'b1, 8'd3});
        // Asynchronous reset mid-stream, away from any clock edge
        #2; reset = 1'b1; #1;
        check("async_rst_valid", idex_valid, 0);
        check("async_rst_pc", idex_pc, 0);
        tick(); reset = 1'b0;

        // JMP to 8'h08 at PC 2
        feed(alu(3'd1, 3'd0, 3'd0), 8'd0); tick();
        feed(alu(3'd2, 3'd0, 3'd0), 8'd1); tick();
        feed(jmp(8'h08), 8'd2); tick();
        feed(alu(3'd7, 3'd0, 3'd0), 8'd3);
        check("idj_redirect", {pc_mux_sel, jmp_loc}, {1'b0, 8'h08});
        tick();
        check("idj_idex_jmp", {idex_valid, idex_opcode, idex_imm, idex_pc}, {1'b1, 5'b11000, 8'h08, 8'd2});
        feed(alu(3'd6, 3'd0, 3'd0), 8'h08);
        check("idj_one_cycle", {pc_mux_sel, jmp_loc}, {1'b1, 8'h08});
        tick();
        check("idj_bubble", idex_valid, 0);
        feed(alu(3'd5, 3'd0, 3'd0), 8'h09); tick();
        check("idj_target", {idex_valid, idex_pc, idex_rd}, {1'b1, 8'h08, 3'd6});

        // Load-use via rs1
        do_reset();
        feed(ld(3'd3, 3'd0), 8'd4); tick();
        feed(alu(3'd1, 3'd3, 3'd0), 8'd5); tick();
        feed(alu(3'd2, 3'd0, 3'd0), 8'd6);
        check("lu1_stall", {stall, stall_pm, pc_mux_sel}, 3'b111);
        tick();
        check("lu1_bubble", idex_valid, 0);
        check("lu1_release", {stall, stall_pm}, 2'b00);
        tick();
        check("lu1_late", {idex_valid, idex_pc, idex_rs1}, {1'b1, 8'd5, 3'd3});

        // Load-use via rs2
        do_reset();
        feed(ld(3'd3, 3'd0), 8'd4); tick();
        feed(alu(3'd1, 3'd0, 3'd3), 8'd5); tick();
        feed(alu(3'd2, 3'd0, 3'd0), 8'd6);
        check("lu2_stall", {stall, stall_pm}, 2'b11);
        tick();
        check("lu2_bubble", idex_valid, 0);
        tick();
        check("lu2_late", {idex_valid, idex_pc}, {1'b1, 8'd5});

        // LOAD rd=3 then JMP whose imm aliases rs2=3 (8'hC0): no stall
        do_reset();
        feed(ld(3'd3, 3'd0), 8'd4); tick();
        feed(jmp(8'hC0), 8'd5); tick();
        feed(alu(3'd2, 3'd0, 3'd0), 8'd6);
        check("alias_rs2", rs2_addr, 3'd3);
        check("alias_nostall", {stall, stall_pm, pc_mux_sel, jmp_loc}, {3'b000, 8'hC0});

        // ex_redirect together with an ID jump
        do_reset();
        feed(jmp(8'h08), 8'd2); tick();
        feed(alu(3'd1, 3'd0, 3'd0), 8'd3);
        ex_redirect = 1'b1; ex_target = 8'h20; #1;
        check("exr_idj_loc", {pc_mux_sel, stall, jmp_loc}, {2'b00, 8'h20});
        tick();
        ex_redirect = 1'b0;
        feed(alu(3'd4, 3'd0, 3'd0), 8'h20);
        check("exr_idj_bubble", idex_valid, 0);
        check("exr_hold", {pc_mux_sel, jmp_loc}, {1'b1, 8'h20});
        tick();
        check("exr_bubble2", idex_valid, 0);
        feed(alu(3'd5, 3'd0, 3'd0), 8'h21); tick();
        check("exr_target", {idex_valid, idex_pc}, {1'b1, 8'h20});

        // ex_redirect together with a load-use hazard
        do_reset();
        feed(ld(3'd3, 3'd0), 8'd4); tick();
        feed(alu(3'd1, 3'd3, 3'd0), 8'd5); tick();
        ex_redirect = 1'b1; ex_target = 8'h30; #1;
        check("exr_haz_ctl", {stall, stall_pm, pc_mux_sel, jmp_loc}, {3'b000, 8'h30});
        tick();
        ex_redirect = 1'b0; #1;
        check("exr_haz_bubble", idex_valid, 0);
        check("exr_haz_nostall", stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
